// File: rtl/fifo_rd_stream.sv
// Burst reader: pops a sync FIFO into a 2-entry skid buffer and presents the
// words on a valid/ready stream, with last/done framing and abort.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; counters and buffer empty
// RUN   | fetching from FIFO and streaming until the last handshake/abort
module fifo_rd_stream #(
   parameter int W    = 8,
   parameter int MAXB = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [3:0]   burst_len,
   input  logic         abort,
   input  logic         fifo_empty,
   input  logic [W-1:0] fifo_rd_data,
   output logic         fifo_rd_en,
   output logic         m_valid,
   output logic [W-1:0] m_data,
   output logic         m_last,
   input  logic         m_ready,
   output logic         busy,
   output logic         done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [4:0] MAXB5 = 5'(MAXB);

   state_t       state, state_nxt;
   logic [4:0]   fetch_rem, send_rem;
   logic [4:0]   len5;
   logic [1:0]   buf_cnt;
   logic         rd_ptr, wr_ptr;
   logic [W-1:0] buf_mem [2];
   logic         hs, last_hs;

   always_comb begin
      len5       = (burst_len == 4'd0) ? MAXB5 : {1'b0, burst_len};
      busy       = (state == RUN);
      m_valid    = (buf_cnt != 2'd0);
      m_data     = m_valid ? buf_mem[rd_ptr] : '0;
      m_last     = m_valid & (send_rem == 5'd1);
      hs         = m_valid & m_ready;
      last_hs    = hs & (send_rem == 5'd1);
      // pop decision deliberately ignores m_ready; the buffer absorbs backpressure
      fifo_rd_en = (state == RUN) & ~fifo_empty & (fetch_rem != 5'd0)
                   & (buf_cnt < 2'd2) & ~abort;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN:  if (abort || last_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fetch_rem <= 5'd0;
         send_rem  <= 5'd0;
         buf_cnt   <= 2'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == RUN) & last_hs & ~abort;
         if (state == IDLE) begin
            if (start) begin
               fetch_rem <= len5;
               send_rem  <= len5;
            end
            buf_cnt <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
         end else if (abort) begin
            fetch_rem <= 5'd0;
            send_rem  <= 5'd0;
            buf_cnt   <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
         end else begin
            if (fifo_rd_en) begin
               fetch_rem <= fetch_rem - 5'd1;
               wr_ptr    <= ~wr_ptr;
            end
            if (hs) begin
               send_rem <= send_rem - 5'd1;
               rd_ptr   <= ~rd_ptr;
            end
            case ({fifo_rd_en, hs})
               2'b10:   buf_cnt <= buf_cnt + 2'd1;
               2'b01:   buf_cnt <= buf_cnt - 2'd1;
               default: buf_cnt <= buf_cnt;
            endcase
         end
      end
   end

   // storage needs no reset: m_data is masked while the buffer is empty
   always_ff @(posedge clk) begin
      if (fifo_rd_en) buf_mem[wr_ptr] <= fifo_rd_data;
   end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter MAXB, default 16, giving the maximum burst length in words; burst_len value 0 SHALL encode MAXB.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be exactly:
  clk  input  1  clock, all state on rising edge
  reset  input  1  asynchronous, active-high reset
  start  input  1  one-cycle burst request, sampled only in IDLE
  burst_len  input  4  words per burst, latched on accepted start
  abort  input  1  synchronous burst cancel
  fifo_empty  input  1  sync FIFO empty flag, fast mode
  fifo_rd_data  input  W  sync FIFO head word, combinational, fast mode
  fifo_rd_en  output  1  FIFO pop strobe
  m_valid  output  1  stream word valid
  m_data  output  W  stream word
  m_last  output  1  final word of burst, qualified by m_valid
  m_ready  input  1  stream sink ready
  busy  output  1  high in RUN
  done  output  1  one-cycle pulse after the last word handshake

Function
REQ-005 FSM states SHALL be IDLE and RUN; IDLE->RUN on start; RUN->IDLE on last-word handshake or abort.
REQ-006 On start in IDLE, the block SHALL latch fetch_rem and send_rem = burst_len, or MAXB if burst_len is 0, using 5-bit counters.
REQ-007 start SHALL be ignored in RUN.
REQ-008 fifo_rd_en SHALL be (state==RUN) & !fifo_empty & (fetch_rem!=0) & (buf_cnt<2) & !abort.
REQ-009 fifo_rd_en SHALL have no combinational path from m_ready.
REQ-010 A word popped in cycle N SHALL be written into a 2-entry in-order buffer and SHALL be visible on m_data from cycle N+1.
REQ-011 Each pop SHALL decrement fetch_rem by 1.
REQ-012 m_valid SHALL equal (buf_cnt!=0); m_data SHALL be the buffer head.
REQ-013 m_data and m_valid SHALL hold stable while m_valid & !m_ready.
REQ-014 A handshake (m_valid & m_ready) SHALL pop the buffer head and decrement send_rem by 1.
REQ-015 A simultaneous push and pop SHALL leave buf_cnt unchanged and preserve word order.
REQ-016 A streaming sink (m_ready always 1) with a non-empty FIFO SHALL see one word per cycle after the first.
REQ-017 m_last SHALL equal m_valid & (send_rem==1).
REQ-018 On the last handshake, the block SHALL go to IDLE, and done SHALL be 1 in the next cycle only.
REQ-019 busy SHALL equal (state==RUN).
REQ-020 If fifo_empty goes high mid-burst, the block SHALL stall the pop with no error and resume when the FIFO refills.
REQ-021 abort in RUN SHALL flush the buffer (buf_cnt=0), zero both counters, and return to IDLE next cycle without pulsing done; words already popped are discarded.
REQ-022 abort in IDLE SHALL have no effect.
REQ-023 start in the same cycle as done SHALL be accepted, because the state is already IDLE.

Reset
REQ-024 Reset SHALL force: state=IDLE, buf_cnt=0, fetch_rem=0, send_rem=0, fifo_rd_en=0, m_valid=0, m_last=0, done=0, busy=0.
REQ-025 m_data SHALL be 0 while reset is asserted.
REQ-026 Reset asserted mid-burst SHALL abandon the burst immediately with no done pulse.
REQ-027 Buffer storage contents need not be reset; no buffer entry SHALL be observable while buf_cnt=0.

Verification
REQ-028 Pre-filled FIFO 0x10..0x13, burst_len=4, m_ready=1 -> pops in 4 consecutive cycles, m_data 0x10..0x13 on 4 consecutive cycles, m_last on 0x13, done one cycle later.
REQ-029 burst_len=0, 20 words in FIFO -> exactly 16 pops, m_last on the 16th word, 4 words remain in FIFO.
REQ-030 burst_len=4, m_ready held 0 for 5 cycles after the first valid -> at most 2 pops, m_data stable at the first word, no loss or reorder after release.
REQ-031 FIFO holds 1 word, burst_len=3, further words written 6 cycles later -> fifo_rd_en never high while fifo_empty=1, burst completes with 3 words in order.
REQ-032 abort after 2 of 4 words sent -> IDLE next cycle, m_valid=0, no done; a following start with burst_len=1 delivers the next FIFO word with m_last=1.
REQ-033 reset pulse mid-burst -> all outputs at REQ-024 values the same cycle; a new start after reset works normally.
